pc_gen: RTL and testbench

- Parametrised fetch-stage program counter generator for the pipelined CPU.
- Holds the current fetch PC and advances by a fixed increment under a write enable (stall control from the hazard unit).
- Accepts branch/jump redirects from later stages. A redirect that arrives while the PC is stalled is latched and applied when the stall releases.
- Optionally predicts return targets with a small circular return-address stack (RAS).

---
 rtl/pc_gen.sv | 153 +++++++++++++++
 tb/tb_pc_gen.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter generator.
// Holds the fetch PC, advances it by INC when pc_write_i allows, and takes
// branch/jump redirects. A redirect that arrives during a stall is parked in a
// pending register (state PEND) and applied on the first non-stalled cycle.
// Optional return-address stack, enabled by defining the macro PC_GEN_RAS_EN.
// Without that macro, call_i/ret_i are ignored and ras_empty_o is tied to 1.
module pc_gen #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = {WIDTH{1'b0}},
  parameter int               INC       = 4,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pc_write_i,
  input  logic             redir_i,
  input  logic [WIDTH-1:0] redir_pc_i,
  input  logic             call_i,
  input  logic             ret_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_plus_o,
  output logic             pend_o,
  output logic             ras_empty_o
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] pc_nxt_s;
  logic [WIDTH-1:0] pend_pc_r;
  logic [WIDTH-1:0] pend_pc_nxt_s;
  logic [WIDTH-1:0] pc_plus_s;
  // High only on cycles where the sequential/return path (not a redirect or
  // pending release) chooses the next PC; only then may the RAS change.
  logic             adv_s;
  // A return that can actually be served from the RAS this cycle.
  logic             ras_hit_s;
  logic [WIDTH-1:0] ras_top_s;

  assign pc_plus_s = pc_r + INC_W;   // wraps modulo 2^WIDTH
  assign pc_o      = pc_r;
  assign pc_plus_o = pc_plus_s;
  assign pend_o    = (state_r == PEND);

  // Next-PC priority: redirect, parked redirect, RAS return, increment, hold.
  always_comb begin
    state_nxt_s   = state_r;
    pc_nxt_s      = pc_r;
    pend_pc_nxt_s = pend_pc_r;
    adv_s         = 1'b0;
    if (redir_i && pc_write_i) begin
      // A live redirect also supersedes any redirect still parked.
      pc_nxt_s    = redir_pc_i;
      state_nxt_s = RUN;
    end else if (redir_i) begin
      // Stalled: remember only the most recent redirect target.
      pend_pc_nxt_s = redir_pc_i;
      state_nxt_s   = PEND;
    end else if ((state_r == PEND) && pc_write_i) begin
      pc_nxt_s    = pend_pc_r;
      state_nxt_s = RUN;
    end else if (pc_write_i) begin
      adv_s = 1'b1;
      if (ras_hit_s) begin
        pc_nxt_s = ras_top_s;
      end else begin
        pc_nxt_s = pc_plus_s;
      end
    end else begin
      // Stall with nothing new: hold PC and keep any parked redirect.
      pc_nxt_s = pc_r;
    end
  end

  // PC, FSM state and parked redirect target registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_r      <= RESET_VEC;
      state_r   <= RUN;
      pend_pc_r <= {WIDTH{1'b0}};
    end else begin
      pc_r      <= pc_nxt_s;
      state_r   <= state_nxt_s;
      pend_pc_r <= pend_pc_nxt_s;
    end
  end

`ifdef PC_GEN_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

  // Circular stack: ras_ptr_r is the next write slot, the top is ptr-1.
  // When full, a push wraps onto the oldest entry and the count saturates.
  logic [WIDTH-1:0] ras_mem_r [RAS_DEPTH];
  logic [PW-1:0]    ras_ptr_r;
  logic [CW-1:0]    ras_cnt_r;
  logic [PW-1:0]    top_idx_s;

  assign top_idx_s   = ras_ptr_r - PW'(1);
  assign ras_top_s   = ras_mem_r[top_idx_s];
  assign ras_hit_s   = ret_i && (ras_cnt_r != {CW{1'b0}});
  assign ras_empty_o = (ras_cnt_r == {CW{1'b0}});

  // RAS push/pop/replace; only touched on advance cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ras_ptr_r <= {PW{1'b0}};
      ras_cnt_r <= {CW{1'b0}};
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (adv_s) begin
      if (call_i && ras_hit_s) begin
        // Call and return together: swap the top for the new return address.
        ras_mem_r[top_idx_s] <= pc_plus_s;
      end else if (call_i) begin
        ras_mem_r[ras_ptr_r] <= pc_plus_s;
        ras_ptr_r            <= ras_ptr_r + PW'(1);
        if (ras_cnt_r != FULL_CNT) begin
          ras_cnt_r <= ras_cnt_r + CW'(1);
        end else begin
          ras_cnt_r <= ras_cnt_r;
        end
      end else if (ras_hit_s) begin
        ras_ptr_r <= top_idx_s;
        ras_cnt_r <= ras_cnt_r - CW'(1);
      end else begin
        ras_ptr_r <= ras_ptr_r;
        ras_cnt_r <= ras_cnt_r;
      end
    end else begin
      ras_ptr_r <= ras_ptr_r;
      ras_cnt_r <= ras_cnt_r;
    end
  end
`else
  // No RAS: hints are accepted but have no effect.
  logic unused_ras_hints_s;
  assign unused_ras_hints_s = call_i ^ ret_i;
  assign ras_hit_s          = 1'b0;
  assign ras_top_s          = {WIDTH{1'b0}};
  assign ras_empty_o        = 1'b1;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen. Stimulus pushes hand-computed expectations;
// a monitor pops one per clock and compares. A second instance with
// RESET_VEC=0xFFFFFFFC shares the inputs and checks reset-vector wrap.
// Expectations follow PC_GEN_RAS_EN when it is defined.
module tb_pc_gen;

`ifdef PC_GEN_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif
  // Expected ras_empty_o while the RAS should hold entries.
  localparam logic NE = RAS_ON ? 1'b0 : 1'b1;

  logic        clk = 1'b0;
  logic        rst, we, rd, call, ret;
  logic [31:0] rpc;
  logic [31:0] pc, pc_plus, alt_pc, alt_plus;
  logic        pend, empty, alt_pend, alt_empty;

  pc_gen #(.WIDTH(32), .RESET_VEC(32'h0), .INC(4), .RAS_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .pc_write_i(we), .redir_i(rd), .redir_pc_i(rpc),
    .call_i(call), .ret_i(ret), .pc_o(pc), .pc_plus_o(pc_plus),
    .pend_o(pend), .ras_empty_o(empty));

  pc_gen #(.WIDTH(32), .RESET_VEC(32'hFFFF_FFFC), .INC(4), .RAS_DEPTH(4)) dut_alt (
    .clk_i(clk), .rst_i(rst), .pc_write_i(we), .redir_i(rd), .redir_pc_i(rpc),
    .call_i(call), .ret_i(ret), .pc_o(alt_pc), .pc_plus_o(alt_plus),
    .pend_o(alt_pend), .ras_empty_o(alt_empty));

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic        pend;
    logic        empty;
    logic        alt_chk;
    logic [31:0] alt_pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_step  = 0;

  function automatic logic [31:0] pick(input logic [31:0] with_ras, input logic [31:0] no_ras);
    return RAS_ON ? with_ras : no_ras;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the state expected after the edge.
  task automatic step(input logic r, input logic w, input logic d, input logic [31:0] tgt,
                      input logic c, input logic t, input logic [31:0] epc,
                      input logic epend, input logic eempty,
                      input logic achk = 1'b0, input logic [31:0] apc = 32'h0);
    exp_t e;
    @(negedge clk);
    rst = r; we = w; rd = d; rpc = tgt; call = c; ret = t;
    e.idx = n_step; e.pc = epc; e.pend = epend; e.empty = eempty;
    e.alt_chk = achk; e.alt_pc = apc;
    exp_q.push_back(e);
    n_step++;
    @(posedge clk);
  endtask

  // Monitor: one output snapshot per clock, just after the active edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc_o", e.idx, pc, e.pc);
      chk("pc_plus_o", e.idx, pc_plus, e.pc + 32'h4);
      chk("pend_o", e.idx, {31'h0, pend}, {31'h0, e.pend});
      chk("ras_empty_o", e.idx, {31'h0, empty}, {31'h0, e.empty});
      if (e.alt_chk) begin
        chk("alt_pc_o", e.idx, alt_pc, e.alt_pc);
        chk("alt_pc_plus_o", e.idx, alt_plus, e.alt_pc + 32'h4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; we = 1'b0; rd = 1'b0; rpc = 32'h0; call = 1'b0; ret = 1'b0;
    // Reset and sequential advance; alt instance wraps from 0xFFFFFFFC.
    step(1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 1, 32'hFFFF_FFFC);
    step(0, 1, 0, 32'h0, 0, 0, 32'h4, 0, 1, 1, 32'h0);
    step(0, 1, 0, 32'h0, 0, 0, 32'h8, 0, 1, 1, 32'h4);
    step(0, 1, 0, 32'h0, 0, 0, 32'hC, 0, 1);
    for (int a = 16; a <= 32; a += 4) step(0, 1, 0, 32'h0, 0, 0, a, 0, 1);
    // Stalled redirects: latest wins, released on first write cycle.
    step(0, 0, 1, 32'h100, 0, 0, 32'h20, 1, 1);
    step(0, 0, 1, 32'h200, 0, 0, 32'h20, 1, 1);
    step(0, 1, 0, 32'h0, 0, 0, 32'h200, 0, 1);
    // Reset while PEND clears the parked redirect.
    step(0, 0, 1, 32'h300, 0, 0, 32'h200, 1, 1);
    step(1, 0, 1, 32'h300, 0, 0, 32'h0, 0, 1);
    step(0, 1, 0, 32'h0, 0, 0, 32'h4, 0, 1);
    step(0, 0, 0, 32'h0, 0, 0, 32'h4, 0, 1);
    // A live redirect supersedes a parked one.
    step(0, 0, 1, 32'h500, 0, 0, 32'h4, 1, 1);
    step(0, 1, 1, 32'h600, 0, 0, 32'h600, 0, 1);
    // Call at 0x40, redirect, return at 0x408.
    step(0, 1, 1, 32'h40, 0, 0, 32'h40, 0, 1);
    step(0, 1, 0, 32'h0, 1, 0, 32'h44, 0, NE);
    step(0, 1, 1, 32'h400, 0, 0, 32'h400, 0, NE);
    step(0, 1, 0, 32'h0, 0, 0, 32'h404, 0, NE);
    step(0, 1, 0, 32'h0, 0, 0, 32'h408, 0, NE);
    step(0, 1, 0, 32'h0, 0, 1, pick(32'h44, 32'h40C), 0, 1);
    // Redirect together with ret: redirect wins, RAS untouched.
    step(0, 1, 1, 32'h44, 0, 0, 32'h44, 0, 1);
    step(0, 1, 0, 32'h0, 1, 0, 32'h48, 0, NE);
    step(0, 1, 1, 32'h700, 0, 1, 32'h700, 0, NE);
    step(0, 1, 0, 32'h0, 0, 1, pick(32'h48, 32'h704), 0, 1);
    // call+ret together: empty -> push+increment; non-empty -> swap top.
    step(0, 1, 1, 32'h800, 0, 0, 32'h800, 0, 1);
    step(0, 1, 0, 32'h0, 1, 1, 32'h804, 0, NE);
    step(0, 1, 0, 32'h0, 1, 1, pick(32'h804, 32'h808), 0, NE);
    step(0, 1, 0, 32'h0, 0, 1, pick(32'h808, 32'h80C), 0, 1);
    // Five calls overflow a 4-deep RAS; the oldest entry is lost.
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 1, 32'(k * 16), 0, 0, 32'(k * 16), 0, (k == 0) ? 1'b1 : NE);
      step(0, 1, 0, 32'h0, 1, 0, 32'(k * 16 + 4), 0, NE);
    end
    step(0, 1, 1, 32'h900, 0, 0, 32'h900, 0, NE);
    step(0, 1, 0, 32'h0, 0, 1, pick(32'h44, 32'h904), 0, NE);
    step(0, 1, 0, 32'h0, 0, 1, pick(32'h34, 32'h908), 0, NE);
    step(0, 1, 0, 32'h0, 0, 1, pick(32'h24, 32'h90C), 0, NE);
    step(0, 1, 0, 32'h0, 0, 1, pick(32'h14, 32'h910), 0, 1);
    step(0, 1, 0, 32'h0, 0, 1, pick(32'h18, 32'h914), 0, 1);
    // ret on a pending-release cycle is ignored.
    step(0, 0, 1, 32'hA00, 0, 0, pick(32'h18, 32'h914), 1, 1);
    step(0, 1, 0, 32'h0, 0, 1, 32'hA00, 0, 1);
    // PC wrap at the top of the address space.
    step(0, 1, 1, 32'hFFFF_FFF8, 0, 0, 32'hFFFF_FFF8, 0, 1);
    step(0, 1, 0, 32'h0, 0, 0, 32'hFFFF_FFFC, 0, 1);
    step(0, 1, 0, 32'h0, 0, 0, 32'h0, 0, 1);
    @(negedge clk);
    we = 1'b0;
    n_total++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: got %0d expected 0 queued", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
